// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store master: request size codes,
// FSM state type and word geometry.
package lsu_pkg;

    localparam logic [1:0] LSU_BYTE = 2'b00;
    localparam logic [1:0] LSU_HALF = 2'b01;
    localparam logic [1:0] LSU_WORD = 2'b10;
    localparam logic [1:0] LSU_RSVD = 2'b11;

    localparam int LSU_WORD_BYTES = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_WRITE = 2'b10,
        ST_RESP  = 2'b11
    } lsu_state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane handling for the load/store master:
// extracts and extends the addressed byte/halfword of a read word,
// and merges sub-word store data into the old word.
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [1:0]       i_size,
    input  logic             i_unsigned,
    input  logic [1:0]       i_addr_lo,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [WIDTH-1:0] i_rword,
    output logic [WIDTH-1:0] o_load_data,
    output logic [WIDTH-1:0] o_store_word
);

    logic [4:0]       w_shift;
    logic [WIDTH-1:0] w_mask;
    logic [WIDTH-1:0] w_lane;

    // Lane shift/mask selection, load extension and store merge.
    // A word access uses shift 0 and a full mask, so the merge
    // degenerates to plain store data.
    always_comb begin
        w_shift = '0;
        w_mask  = '1;
        case (i_size)
            LSU_BYTE: begin
                w_shift = {i_addr_lo, 3'b000};
                w_mask  = {{(WIDTH-8){1'b0}}, 8'hFF};
            end
            LSU_HALF: begin
                w_shift = {i_addr_lo[1], 4'b0000};
                w_mask  = {{(WIDTH-16){1'b0}}, 16'hFFFF};
            end
            default: ;
        endcase

        w_lane      = i_rword >> w_shift;
        o_load_data = w_lane;
        case (i_size)
            LSU_BYTE: o_load_data = {{(WIDTH-8){w_lane[7] & ~i_unsigned}}, w_lane[7:0]};
            LSU_HALF: o_load_data = {{(WIDTH-16){w_lane[15] & ~i_unsigned}}, w_lane[15:0]};
            default:  ;
        endcase

        o_store_word = (i_rword & ~(w_mask << w_shift)) | ((i_wdata & w_mask) << w_shift);
    end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store master driving a word-indexed, combinational-read data memory.
// Optional feature: define LSU_RANGE_CHECK_EN to reject word indices at or
// beyond MEM_DEPTH with an error response and no memory access.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | ready for a request; memory outputs held at 0
// READ    | memory addressed, read word captured (load result or old word)
// WRITE   | mem_write_read high; word committed at the closing edge
// RESP    | one-cycle response pulse, then back to IDLE
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int MEM_DEPTH = 256
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [1:0]       req_size,
    input  logic             req_unsigned,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             resp_valid,
    output logic [WIDTH-1:0] resp_rdata,
    output logic             resp_error,
    output logic             mem_write_read,
    output logic [WIDTH-1:0] mem_address,
    output logic [WIDTH-1:0] mem_write_data,
    input  logic [WIDTH-1:0] mem_read_data
);

    lsu_state_t       r_state;
    logic             r_write;
    logic [1:0]       r_size;
    logic             r_unsigned;
    logic [1:0]       r_addr_lo;
    logic [WIDTH-1:0] r_wdata;
    logic             r_req_ready;
    logic             r_resp_valid;
    logic [WIDTH-1:0] r_resp_rdata;
    logic             r_resp_error;
    logic             r_mem_we;
    logic [WIDTH-1:0] r_mem_addr;
    logic [WIDTH-1:0] r_mem_wdata;

    logic [WIDTH-1:0] w_word_idx;
    logic             w_misalign;
    logic             w_out_of_range;
    logic             w_req_err;
    logic [WIDTH-1:0] w_load_data;
    logic [WIDTH-1:0] w_store_word;

    assign w_word_idx = {2'b00, req_addr[WIDTH-1:2]};

    // Acceptance-time rejection: misalignment, reserved size, optional range.
    always_comb begin
        w_misalign = (req_size == LSU_RSVD)
                  || ((req_size == LSU_HALF) && req_addr[0])
                  || ((req_size == LSU_WORD) && (req_addr[1:0] != 2'b00));
`ifdef LSU_RANGE_CHECK_EN
        w_out_of_range = (w_word_idx >= WIDTH'(MEM_DEPTH));
`else
        w_out_of_range = 1'b0;
`endif
        w_req_err = w_misalign || w_out_of_range;
    end

    lsu_lane_align #(
        .WIDTH (WIDTH)
    ) u_lane_align (
        .i_size       (r_size),
        .i_unsigned   (r_unsigned),
        .i_addr_lo    (r_addr_lo),
        .i_wdata      (r_wdata),
        .i_rword      (mem_read_data),
        .o_load_data  (w_load_data),
        .o_store_word (w_store_word)
    );

    // Request FSM with all outputs registered; reset aborts any access at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_write      <= 1'b0;
            r_size       <= LSU_BYTE;
            r_unsigned   <= 1'b0;
            r_addr_lo    <= 2'b00;
            r_wdata      <= '0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_error <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_error <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid && r_req_ready) begin
                        r_write     <= req_write;
                        r_size      <= req_size;
                        r_unsigned  <= req_unsigned;
                        r_addr_lo   <= req_addr[1:0];
                        r_wdata     <= req_wdata;
                        r_req_ready <= 1'b0;
                        if (w_req_err) begin
                            r_state      <= ST_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_error <= 1'b1;
                        end else if (req_write && (req_size == LSU_WORD)) begin
                            r_state     <= ST_WRITE;
                            r_mem_we    <= 1'b1;
                            r_mem_addr  <= w_word_idx;
                            r_mem_wdata <= req_wdata;
                        end else begin
                            r_state    <= ST_READ;
                            r_mem_addr <= w_word_idx;
                        end
                    end
                end
                ST_READ: begin
                    if (r_write) begin
                        // Old word is read this cycle; the merged word is what gets written.
                        r_state     <= ST_WRITE;
                        r_mem_we    <= 1'b1;
                        r_mem_wdata <= w_store_word;
                    end else begin
                        r_state      <= ST_RESP;
                        r_mem_addr   <= '0;
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= w_load_data;
                    end
                end
                ST_WRITE: begin
                    r_state      <= ST_RESP;
                    r_mem_we     <= 1'b0;
                    r_mem_addr   <= '0;
                    r_mem_wdata  <= '0;
                    r_resp_valid <= 1'b1;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_req_ready <= 1'b1;
                    r_mem_we    <= 1'b0;
                    r_mem_addr  <= '0;
                    r_mem_wdata <= '0;
                end
            endcase
        end
    end

    assign req_ready      = r_req_ready;
    assign resp_valid     = r_resp_valid;
    assign resp_rdata     = r_resp_rdata;
    assign resp_error     = r_resp_error;
    assign mem_write_read = r_mem_we;
    assign mem_address    = r_mem_addr;
    assign mem_write_data = r_mem_wdata;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Bench for lsu_mem_master: behavioural memory, reference model producing
// a per-cycle expected trace, directed scenarios and randomized traffic.
// Honours LSU_RANGE_CHECK_EN the same way as the design.
module tb_lsu_mem_master;

    localparam int W     = 32;
    localparam int DEPTH = 256;
    localparam int BM    = 1024;
`ifdef LSU_RANGE_CHECK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          req_valid, req_ready, req_write, req_unsigned;
    logic [1:0]    req_size;
    logic [W-1:0]  req_addr, req_wdata;
    logic          resp_valid, resp_error;
    logic [W-1:0]  resp_rdata;
    logic          mem_write_read;
    logic [W-1:0]  mem_address, mem_write_data, mem_read_data;

    always #5 clk = ~clk;

    lsu_mem_master #(.WIDTH(W), .MEM_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_size       (req_size),
        .req_unsigned   (req_unsigned),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_error     (resp_error),
        .mem_write_read (mem_write_read),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    // Environment memory (what the DUT talks to) and the model's shadow copy.
    logic [31:0] mem     [BM];
    logic [31:0] ref_mem [BM];
    logic        pl_we = 1'b0;
    logic [9:0]  pl_idx = '0;
    logic [31:0] pl_data = '0;

    assign mem_read_data = mem[mem_address[9:0]];

    always @(posedge clk) begin
        if (pl_we)               mem[pl_idx] <= pl_data;
        else if (mem_write_read) mem[mem_address[9:0]] <= mem_write_data;
    end

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    typedef struct {
        logic        ready, rv, err, we, wd_chk;
        logic [31:0] rdata, addr, wd;
    } exp_t;

    exp_t exp_q[$];
    bit   chk_en = 1'b0;

    int unsigned resp_seen = 0, we_seen = 0, resp_cyc = 0;
    logic [31:0] last_rdata = '0, last_maddr = '0;
    logic        last_err = 1'b0;

    // Single compare process: one expected entry per cycle, idle when the queue is empty.
    always @(negedge clk) begin : cmp
        exp_t e;
        if (resp_valid) begin
            resp_seen++;
            last_rdata = resp_rdata;
            last_err   = resp_error;
            resp_cyc   = cyc;
        end
        if (mem_write_read) we_seen++;
        if (mem_address != 0) last_maddr = mem_address;
        if (chk_en) begin
            e.ready = 1'b1; e.rv = 1'b0; e.err = 1'b0; e.we = 1'b0; e.wd_chk = 1'b1;
            e.rdata = '0; e.addr = '0; e.wd = '0;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            chk("req_ready",      32'(req_ready),      32'(e.ready));
            chk("resp_valid",     32'(resp_valid),     32'(e.rv));
            chk("resp_error",     32'(resp_error),     32'(e.err));
            chk("resp_rdata",     resp_rdata,          e.rdata);
            chk("mem_write_read", 32'(mem_write_read), 32'(e.we));
            chk("mem_address",    mem_address,         e.addr);
            if (e.wd_chk) chk("mem_write_data", mem_write_data, e.wd);
        end
    end

    // Reference model: from the request alone, predict every cycle after acceptance.
    task automatic model_req(input logic wr, input logic [1:0] sz, input logic uns,
                             input logic [31:0] a, input logic [31:0] wd,
                             output logic [31:0] m_rdata, output logic m_err);
        int unsigned idx, nb, sh;
        logic [31:0] mask, word, val, nw;
        exp_t base, e;
        idx  = a >> 2;
        nb   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        sh   = 8 * int'(a[1:0]);
        mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 1);
        m_err = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0)
             || (RANGE_EN && idx >= DEPTH);
        m_rdata = '0;
        base.ready = 1'b0; base.rv = 1'b0; base.err = 1'b0; base.we = 1'b0; base.wd_chk = 1'b1;
        base.rdata = '0; base.addr = '0; base.wd = '0;
        if (m_err) begin
            e = base; e.rv = 1'b1; e.err = 1'b1; exp_q.push_back(e);
            return;
        end
        word = ref_mem[idx % BM];
        if (!wr) begin
            val = (word >> sh) & mask;
            if (!uns && nb < 4 && val[8*nb-1]) val = val | ~mask;
            m_rdata = val;
            e = base; e.addr = 32'(idx); e.wd_chk = 1'b0; exp_q.push_back(e);
            e = base; e.rv = 1'b1; e.rdata = val; exp_q.push_back(e);
        end else begin
            nw = (word & ~(mask << sh)) | ((wd & mask) << sh);
            ref_mem[idx % BM] = nw;
            if (nb < 4) begin
                e = base; e.addr = 32'(idx); e.wd_chk = 1'b0; exp_q.push_back(e);
            end
            e = base; e.we = 1'b1; e.addr = 32'(idx); e.wd = nw; exp_q.push_back(e);
            e = base; e.rv = 1'b1; exp_q.push_back(e);
        end
    endtask

    // Issue one request from the start of an idle cycle; returns model result and latency.
    task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] m_rdata, output logic m_err, output int lat);
        int unsigned acc;
        int k;
        req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd;
        acc = cyc;
        @(posedge clk);
        model_req(wr, sz, uns, a, wd, m_rdata, m_err);
        k = exp_q.size();
        for (int i = 0; i < k; i++) begin
            #1;
            req_valid    = 1'($urandom_range(0, 1));
            req_write    = 1'($urandom_range(0, 1));
            req_size     = 2'($urandom_range(0, 3));
            req_unsigned = 1'($urandom_range(0, 1));
            req_addr     = $urandom;
            req_wdata    = $urandom;
            @(posedge clk);
        end
        #1;
        req_valid = 1'b0;
        lat = int'(resp_cyc - acc);
    endtask

    task automatic poke(input int idx, input logic [31:0] v);
        pl_we = 1'b1; pl_idx = 10'(idx); pl_data = v;
        ref_mem[idx] = v;
        @(posedge clk);
        #1;
        pl_we = 1'b0;
    endtask

    initial begin
        logic [31:0] mr;
        logic        me;
        int          lat;
        int unsigned w0, r0, bad;
        logic        wr, uns;
        logic [1:0]  sz, lo;
        int unsigned idx;

        req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0;

        // Preload while the DUT is held in reset.
        @(posedge clk); #1;
        for (int i = 0; i < BM; i++) poke(i, $urandom);

        @(negedge clk);
        chk("rst_req_ready",  32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_error", 32'(resp_error), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_mem_we",     32'(mem_write_read), 32'd0);
        chk("rst_mem_addr",   mem_address, 32'd0);
        chk("rst_mem_wdata",  mem_write_data, 32'd0);
        reset = 1'b1;
        #1 chk_en = 1'b1;
        @(posedge clk); #1;

        // Word store then word load at 0x10.
        do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, mr, me, lat);
        chk("ws_lat", 32'(lat), 32'd2);
        chk("ws_mem4", mem[4], 32'hDEADBEEF);
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, mr, me, lat);
        chk("lw_lat", 32'(lat), 32'd2);
        chk("lw_dut", last_rdata, 32'hDEADBEEF);

        // Byte store into 0x11223344.
        poke(4, 32'h11223344);
        w0 = we_seen;
        do_req(1'b1, 2'd0, 1'b0, 32'h11, 32'h000000AA, mr, me, lat);
        chk("sb_lat", 32'(lat), 32'd3);
        chk("sb_mem4", mem[4], 32'h1122AA44);
        chk("sb_we_cycles", we_seen - w0, 32'd1);

        // Sub-word loads of 0x80FF0000.
        poke(4, 32'h80FF0000);
        do_req(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, mr, me, lat);
        chk("lb_s_model", mr, 32'hFFFFFF80);
        chk("lb_s_dut", last_rdata, 32'hFFFFFF80);
        do_req(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, mr, me, lat);
        chk("lb_u_model", mr, 32'h00000080);
        chk("lb_u_dut", last_rdata, 32'h00000080);
        do_req(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, mr, me, lat);
        chk("lh_s_model", mr, 32'hFFFF80FF);
        chk("lh_s_dut", last_rdata, 32'hFFFF80FF);

        // Rejected requests: no memory traffic, error at T+1.
        w0 = we_seen;
        do_req(1'b0, 2'd1, 1'b0, 32'h01, 32'h0, mr, me, lat);
        chk("err_half_lat", 32'(lat), 32'd1);
        chk("err_half_flag", 32'(last_err), 32'd1);
        chk("err_half_rdata", last_rdata, 32'd0);
        do_req(1'b1, 2'd2, 1'b0, 32'h06, 32'h55AA55AA, mr, me, lat);
        chk("err_word_flag", 32'(last_err), 32'd1);
        do_req(1'b0, 2'd3, 1'b0, 32'h20, 32'h0, mr, me, lat);
        chk("err_rsvd_flag", 32'(last_err), 32'd1);
        chk("err_we_cycles", we_seen - w0, 32'd0);

        // Word load beyond MEM_DEPTH.
        do_req(1'b0, 2'd2, 1'b0, 32'h400, 32'h0, mr, me, lat);
`ifdef LSU_RANGE_CHECK_EN
        chk("range_err", 32'(last_err), 32'd1);
        chk("range_lat", 32'(lat), 32'd1);
`else
        chk("range_noerr", 32'(last_err), 32'd0);
        chk("range_addr", last_maddr, 32'h100);
        chk("range_lat", 32'(lat), 32'd2);
`endif

        // Reset during the WRITE cycle of a word store.
        poke(8, 32'hCAFEF00D);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h20; req_wdata = 32'h12345678;
        @(posedge clk);
        chk_en = 1'b0;
        #1 req_valid = 1'b0;
        r0 = resp_seen;
        @(negedge clk);
        chk("rt_we_before", 32'(mem_write_read), 32'd1);
        #1 reset = 1'b0;
        #1;
        chk("rt_we_drop", 32'(mem_write_read), 32'd0);
        chk("rt_ready_in_rst", 32'(req_ready), 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rt_ready_after", 32'(req_ready), 32'd1);
        chk("rt_no_resp", resp_seen - r0, 32'd0);
        chk("rt_mem8", mem[8], 32'hCAFEF00D);
        #1 chk_en = 1'b1;
        @(posedge clk); #1;

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            wr  = 1'($urandom_range(0, 1));
            uns = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
                0, 1, 2: sz = 2'd0;
                3, 4, 5: sz = 2'd1;
                6, 7, 8: sz = 2'd2;
                default: sz = 2'd3;
            endcase
            idx = ($urandom_range(0, 9) == 0) ? $urandom_range(DEPTH, BM - 1) : $urandom_range(0, DEPTH - 1);
            lo  = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 4) != 0) begin
                if (sz == 2'd1) lo[0] = 1'b0;
                if (sz == 2'd2) lo = 2'd0;
            end
            do_req(wr, sz, uns, {idx[29:0], lo}, $urandom, mr, me, lat);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        repeat (3) @(posedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        bad = 0;
        for (int i = 0; i < BM; i++) if (mem[i] !== ref_mem[i]) bad++;
        chk("mem_final_bad_words", bad, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/lsu_mem_master.md
# lsu_mem_master

Load/store master that drives the data-memory port of the core on behalf of the execute stage. Accepts one byte/halfword/word load or store per request over a valid/ready handshake and issues word-wide accesses to the word-indexed data memory: combinational read, write committed on the clock edge while `mem_write_read` is high. It performs lane extraction and sign extension for loads, and read-modify-write for sub-word stores. It reports misaligned, reserved-size and out-of-range requests as errors without touching memory.

## Interface
- `WIDTH`, 32: data and byte-address width.
- `MEM_DEPTH`, 256: memory depth in words; used by the range check.
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request.
- `req_write`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
- `req_unsigned`  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- `req_addr`  in  WIDTH  byte address.
- `req_wdata`  in  WIDTH  store data; low bytes are used for sub-word stores.
- `resp_valid`  out  1  single-cycle response pulse.
- `resp_rdata`  out  WIDTH  load result; 0 for stores and errors.
- `resp_error`  out  1  qualifies `resp_valid`; request was rejected.
- `mem_write_read`  out  1  to memory: 1 = write this cycle.
- `mem_address`  out  WIDTH  word index, `{2'b00, addr[WIDTH-1:2]}`.
- `mem_write_data`  out  WIDTH  word to write.
- `mem_read_data`  in  WIDTH  combinational read word.

## Operation
- FSM states: IDLE, READ, WRITE, RESP.
- `req_ready` = 1 only in IDLE. The block accepts a request on `req_valid && req_ready` and registers all request fields.
- Error check at acceptance: half with `addr[0]`≠0, word with `addr[1:0]`≠0, size 11, or (range check, see Configuration) word index ≥ `MEM_DEPTH`. An erroring request goes IDLE→RESP with `resp_error`=1 and makes no memory access.
- Load: IDLE→READ→RESP. READ drives `mem_address`, holds `mem_write_read`=0 and captures the lane-extracted, extended value.
  - Byte lane = `addr[1:0]`. Halfword lane = `addr[1]`.
  - Sign extension uses the MSB of the lane unless `req_unsigned`=1.
- Word store: IDLE→WRITE→RESP. `mem_write_data` = `req_wdata`.
- Sub-word store: IDLE→READ→WRITE→RESP.
  - READ captures the old word.
  - WRITE writes the old word with the target byte/halfword lane replaced by `req_wdata[7:0]` / `[15:0]`.
- RESP: `resp_valid`=1 for exactly one cycle, then →IDLE. There is no response backpressure.
- `mem_write_read` is 1 only in WRITE. `mem_address` and `mem_write_data` are 0 in IDLE and RESP.

## Timing
- Acceptance in cycle T. Latency to `resp_valid`:
  - error: T+1
  - load: T+2
  - word store: T+2 (memory updated at the edge ending T+1)
  - sub-word store: T+3
- Maximum throughput: one request per 3 cycles (loads, word stores). The earliest next acceptance is the cycle after RESP.
- Reset values: state IDLE; `req_ready`=1; every other output 0.
- Reset mid-operation: the FSM returns to IDLE immediately and `mem_write_read` drops combinationally. A WRITE that has not yet reached its clock edge is suppressed and memory is unchanged. No response is issued for the aborted request.
- `req_*` inputs are ignored outside IDLE. Requests presented while not ready must be held by the requester.

## Configuration
- `LSU_RANGE_CHECK_EN` defined: a word index ≥ `MEM_DEPTH` produces `resp_error`=1 with no access.
- Not defined: no range check. `mem_address` passes the full word index and the memory's behaviour beyond its depth applies.

## Structure
- `lsu_pkg`: size encodings (`LSU_BYTE`, `LSU_HALF`, `LSU_WORD`), FSM state enum, `LSU_WORD_BYTES`=4.
- Sub-module `lsu_lane_align`: purely combinational load extract/extend and store merge. `lsu_mem_master` holds the FSM and registers.

## Test plan
- Word store 0xDEADBEEF @0x10, then word load @0x10 → memory word 4 = 0xDEADBEEF; `resp_rdata`=0xDEADBEEF at T+2.
- Byte store 0xAA @0x11 over word 0x11223344 → word = 0x1122AA44; `mem_write_read` high exactly one cycle; response at T+3.
- Byte load @0x13 of 0x80FF0000, signed → 0xFFFFFF80. Unsigned → 0x00000080. Half load @0x12, signed → 0xFFFF80FF.
- Half load @0x01, word store @0x06, size 11 → `resp_error`=1 at T+1; `mem_write_read` never asserted; `resp_rdata`=0.
- With `LSU_RANGE_CHECK_EN`, `MEM_DEPTH`=256: word load @0x400 → error. Without the macro → access issued with `mem_address`=0x100.
- `reset` asserted during WRITE of word store 0x12345678 @0x20 → word 8 unchanged, no `resp_valid`, `req_ready`=1 after reset release.
